// File: rtl/audio_pkg.sv
// Shared types and constants for the audio mixer control sequencer.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    SWAP,
    FADE_IN
  } mix_seq_state_t;

  localparam logic [1:0] MIX_NONE = 2'd0;
  localparam logic [1:0] MIX_25   = 2'd1;
  localparam logic [1:0] MIX_50   = 2'd2;
  localparam logic [1:0] MIX_MONO = 2'd3;

  localparam logic [3:0] DEFAULT_MUTE_ATT = 4'hF;

  // One attenuation code toward tgt, saturating at both ends of the 4-bit range.
  function automatic logic [3:0] att_toward(input logic [3:0] cur, input logic [3:0] tgt);
    if (cur < tgt) return (cur == 4'hF) ? cur : cur + 4'd1;
    if (cur > tgt) return (cur == 4'h0) ? cur : cur - 4'd1;
    return cur;
  endfunction

endpackage

// File: rtl/audio_mix_sequencer_if.sv
// Host settings and mixer control bundle seen by the sequencer.
interface audio_mix_sequencer_if;
  logic       cfg_wr;
  logic [3:0] cfg_vol_att;
  logic [1:0] cfg_mix;
  logic       cfg_mute;
  logic [3:0] vol_att;
  logic [1:0] mix;
  logic       cfg_ack;
  logic       busy;

  modport master (
    output cfg_wr, cfg_vol_att, cfg_mix, cfg_mute,
    input  vol_att, mix, cfg_ack, busy
  );

  modport slave (
    input  cfg_wr, cfg_vol_att, cfg_mix, cfg_mute,
    output vol_att, mix, cfg_ack, busy
  );
endinterface

// File: rtl/audio_step_timer.sv
// Divides sample_tick down to one step pulse every STEP_TICKS ticks.
module audio_step_timer #(
  parameter int STEP_TICKS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic clr,
  output logic step
);
  localparam int CW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_TICKS - 1);

  logic [CW-1:0] cnt;

  if (STEP_TICKS < 1) begin : g_step_chk
    $error("audio_step_timer: STEP_TICKS must be >= 1");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign step = tick && (cnt == LAST) && !clr;

endmodule

// File: rtl/audio_mix_sequencer.sv
// Ramps mixer attenuation one code per step and swaps mix only while muted.
module audio_mix_sequencer
  import audio_pkg::*;
#(
  parameter int         STEP_TICKS = 16,
  parameter logic [3:0] MUTE_ATT   = DEFAULT_MUTE_ATT
) (
  input  logic                   clk_74b,
  input  logic                   reset,
  input  logic                   sample_tick,
  audio_mix_sequencer_if.slave   cfg
);

  mix_seq_state_t state, next_state;
  logic [3:0]     vol_q, tgt_att;
  logic [1:0]     mix_q, tgt_mix;
  logic           ack_q, busy_q;
  logic           step, clr;

  if (STEP_TICKS < 1) begin : g_step_chk
    $error("audio_mix_sequencer: STEP_TICKS must be >= 1");
  end

  // Timer restarts on every state change so each state gets a full first step.
  audio_step_timer #(.STEP_TICKS(STEP_TICKS)) u_step_timer (
    .clk  (clk_74b),
    .rst  (reset),
    .tick (sample_tick),
    .clr  (clr),
    .step (step)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (tgt_mix != mix_q)      next_state = FADE_OUT;
        else if (tgt_att != vol_q) next_state = FADE_IN;
      end
      FADE_OUT: if (vol_q == MUTE_ATT) next_state = SWAP;
      SWAP:     next_state = FADE_IN;
      FADE_IN: begin
        if (tgt_mix != mix_q)      next_state = FADE_OUT;
        else if (vol_q == tgt_att) next_state = IDLE;
      end
      default:  next_state = IDLE;
    endcase
  end

  assign clr = (next_state != state);

  // A step coinciding with a transition is dropped; targets seen here are pre-write.
  always_ff @(posedge clk_74b or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      vol_q   <= MUTE_ATT;
      mix_q   <= MIX_NONE;
      tgt_att <= MUTE_ATT;
      tgt_mix <= MIX_NONE;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (cfg.cfg_wr) begin
        tgt_att <= cfg.cfg_mute ? MUTE_ATT : cfg.cfg_vol_att;
        tgt_mix <= cfg.cfg_mix;
      end
      ack_q  <= cfg.cfg_wr;
      state  <= next_state;
      busy_q <= (next_state != IDLE);
      unique case (state)
        FADE_OUT: if (!clr && step) vol_q <= att_toward(vol_q, MUTE_ATT);
        SWAP:     mix_q <= tgt_mix;
        FADE_IN:  if (!clr && step) vol_q <= att_toward(vol_q, tgt_att);
        default:  ;
      endcase
    end
  end

  assign cfg.vol_att = vol_q;
  assign cfg.mix     = mix_q;
  assign cfg.cfg_ack = ack_q;
  assign cfg.busy    = busy_q;

endmodule
